line_bit_reader: RTL and testbench

Downstream consumer of the line FIFO, in the FIFO's read-clock domain. Pulls one line of bytes (programmable length) from the first-word-fall-through FIFO read port and serialises each byte MSB-first into a bit stream with valid/ready flow control. Frames each line with SOL/EOL markers and enforces a minimum inter-line gap. Flags FIFO starvation in the middle of a line.

---
 rtl/line_reader_pkg.sv | 14 +
 rtl/line_bit_shifter.sv | 44 ++++
 rtl/line_bit_reader.sv | 126 ++++++++++++
 tb/tb_line_bit_reader.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/line_reader_pkg.sv
// Shared types and default sizing for the line bit reader.
package line_reader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        GAP   = 2'd3
    } state_t;

    localparam int LEN_W_DEF      = 15;
    localparam int GAP_CYCLES_DEF = 4;

endpackage

// File: rtl/line_bit_shifter.sv
// Byte serialiser: 8-bit load/shift register with a bit counter.
// Bit order selected by LINE_BIT_READER_LSB_FIRST_EN (default MSB-first).
module line_bit_shifter (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] data,
    input  logic       shift_en,
    output logic       data_bit,
    output logic       first_bit,
    output logic       last_bit
);

    logic [7:0] shreg;
    logic [2:0] bit_cnt;

    // A load wins over a shift so a byte-boundary reload restarts the counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg   <= 8'h00;
            bit_cnt <= 3'd0;
        end else if (load) begin
            shreg   <= data;
            bit_cnt <= 3'd0;
        end else if (shift_en) begin
`ifdef LINE_BIT_READER_LSB_FIRST_EN
            shreg   <= {1'b0, shreg[7:1]};
`else
            shreg   <= {shreg[6:0], 1'b0};
`endif
            bit_cnt <= bit_cnt + 3'd1;
        end
    end

`ifdef LINE_BIT_READER_LSB_FIRST_EN
    assign data_bit = shreg[0];
`else
    assign data_bit = shreg[7];
`endif

    assign first_bit = (bit_cnt == 3'd0);
    assign last_bit  = (bit_cnt == 3'd7);

endmodule

// File: rtl/line_bit_reader.sv
// Pulls one line of bytes from an FWFT FIFO and serialises it with SOL/EOL framing.
// Optional LSB-first order via LINE_BIT_READER_LSB_FIRST_EN (see line_bit_shifter).
module line_bit_reader
    import line_reader_pkg::*;
#(
    parameter int LEN_W      = LEN_W_DEF,
    parameter int GAP_CYCLES = GAP_CYCLES_DEF
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [LEN_W-1:0] LINE_LEN,
    input  logic [7:0]       FIFO_DOUT,
    input  logic             FIFO_EMPTY,
    output logic             FIFO_RD_EN,
    output logic             BIT_OUT,
    output logic             BIT_VALID,
    input  logic             BIT_READY,
    output logic             SOL,
    output logic             EOL,
    output logic             BUSY,
    output logic             LINE_DONE,
    output logic             STARVE,
    input  logic             STARVE_CLR
);

    localparam int GAP_W = $clog2(GAP_CYCLES + 2);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t           state;
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] byte_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic             line_done;
    logic             starve;

    logic in_shift, handshake, last_byte, byte_end, reload, starve_set;
    logic data_bit, first_bit, last_bit;

    assign in_shift   = (state == SHIFT);
    assign handshake  = in_shift && BIT_READY;
    assign last_byte  = (byte_cnt == len - LEN_W'(1));
    assign byte_end   = handshake && last_bit;
    assign reload     = byte_end && !last_byte && !FIFO_EMPTY;
    assign starve_set = (state == LOAD) && FIFO_EMPTY && (byte_cnt != '0);

    // Pop only when a word is present: either the initial fetch or a zero-bubble reload.
    assign FIFO_RD_EN = ((state == LOAD) && !FIFO_EMPTY) || reload;

    line_bit_shifter u_shifter (
        .clk       (CLK),
        .rst       (RST),
        .load      (FIFO_RD_EN),
        .data      (FIFO_DOUT),
        .shift_en  (handshake),
        .data_bit  (data_bit),
        .first_bit (first_bit),
        .last_bit  (last_bit)
    );

    assign BIT_VALID = in_shift;
    assign BIT_OUT   = in_shift && data_bit;
    assign SOL       = in_shift && first_bit && (byte_cnt == '0);
    assign EOL       = in_shift && last_bit && last_byte;
    assign BUSY      = (state != IDLE);
    assign LINE_DONE = line_done;
    assign STARVE    = starve;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            len       <= '0;
            byte_cnt  <= '0;
            gap_cnt   <= '0;
            line_done <= 1'b0;
            starve    <= 1'b0;
        end else begin
            line_done <= 1'b0;
            if (starve_set)
                starve <= 1'b1;
            else if (STARVE_CLR)
                starve <= 1'b0;

            case (state)
                IDLE: begin
                    if (START && (LINE_LEN != '0)) begin
                        len      <= LINE_LEN;
                        byte_cnt <= '0;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    if (!FIFO_EMPTY)
                        state <= SHIFT;
                end
                SHIFT: begin
                    if (byte_end) begin
                        if (last_byte) begin
                            gap_cnt <= '0;
                            if (GAP_CYCLES == 0) begin
                                state     <= IDLE;
                                line_done <= 1'b1;
                            end else begin
                                state <= GAP;
                            end
                        end else begin
                            byte_cnt <= byte_cnt + LEN_W'(1);
                            if (FIFO_EMPTY)
                                state <= LOAD;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state     <= IDLE;
                        line_done <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_line_bit_reader.sv
// Scoreboard bench for line_bit_reader: a FIFO model feeds bytes, expected bit stream is queued per line.
module tb_line_bit_reader;

    localparam int LEN_W = 15;
    localparam int GAP   = 4;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             START = 1'b0;
    logic [LEN_W-1:0] LINE_LEN = '0;
    logic [7:0]       FIFO_DOUT = 8'h00;
    logic             FIFO_EMPTY = 1'b1;
    logic             BIT_READY = 1'b0;
    logic             STARVE_CLR = 1'b0;
    logic             FIFO_RD_EN, BIT_OUT, BIT_VALID, SOL, EOL, BUSY, LINE_DONE, STARVE;

    int vectors = 0;
    int miscompares = 0;

    logic [2:0] exp_q[$];
    logic [7:0] fifo_q[$];
    int   ready_mode = 0;
    int   hold_pct = 0;
    logic hold = 1'b0;
    int   pops = 0;

    line_bit_reader #(.LEN_W(LEN_W), .GAP_CYCLES(GAP)) dut (
        .CLK(CLK), .RST(RST), .START(START), .LINE_LEN(LINE_LEN),
        .FIFO_DOUT(FIFO_DOUT), .FIFO_EMPTY(FIFO_EMPTY), .FIFO_RD_EN(FIFO_RD_EN),
        .BIT_OUT(BIT_OUT), .BIT_VALID(BIT_VALID), .BIT_READY(BIT_READY),
        .SOL(SOL), .EOL(EOL), .BUSY(BUSY), .LINE_DONE(LINE_DONE),
        .STARVE(STARVE), .STARVE_CLR(STARVE_CLR)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic drive_fifo();
        FIFO_EMPTY = hold || (fifo_q.size() == 0);
        FIFO_DOUT  = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
    endtask

    task automatic tick();
        logic p;
        @(posedge CLK);
        p = FIFO_RD_EN;
        #1;
        if (p) begin
            if (fifo_q.size() > 0) void'(fifo_q.pop_front());
            pops++;
        end
        case (ready_mode)
            0:       BIT_READY = 1'b1;
            1:       BIT_READY = ~BIT_READY;
            default: BIT_READY = 1'($urandom_range(0, 1));
        endcase
        hold = (hold_pct > 0) && ($urandom_range(0, 99) < hold_pct);
        drive_fifo();
    endtask

    // Reference: a line of N bytes is 8N bits in byte order, each byte in the selected bit order.
    task automatic expect_line(input logic [7:0] d[$]);
        for (int i = 0; i < d.size(); i++) begin
            for (int b = 0; b < 8; b++) begin
                logic bv;
`ifdef LINE_BIT_READER_LSB_FIRST_EN
                bv = d[i][b];
`else
                bv = d[i][7 - b];
`endif
                exp_q.push_back({bv, (i == 0 && b == 0), (i == d.size() - 1 && b == 7)});
            end
        end
    endtask

    task automatic push_fifo(input logic [7:0] d[$]);
        foreach (d[i]) fifo_q.push_back(d[i]);
        drive_fifo();
    endtask

    task automatic start_line(input int len);
        LINE_LEN = LEN_W'(len);
        START = 1'b1;
        tick();
        START = 1'b0;
    endtask

    task automatic wait_idle(output int n, output int first_v, input bit hammer);
        n = 0;
        first_v = -1;
        while (BUSY && n < 3000) begin
            if (BIT_VALID && first_v < 0) first_v = n;
            if (hammer) START = 1'b1;
            tick();
            n++;
        end
        START = 1'b0;
        check("idle_timeout", 64'(BUSY), 64'd0);
    endtask

    // Monitor: pops expected bits on each handshake, checks stall stability and LINE_DONE timing.
    int         cyc = 0;
    int         due = 0;
    bit         pending = 0;
    bit         prev_stall = 0;
    logic [2:0] prev_v = 3'b000;

    always @(negedge CLK) begin
        logic [2:0] e;
        cyc++;
        if (RST) begin
            pending    = 0;
            prev_stall = 0;
        end else begin
            if (LINE_DONE) begin
                check("line_done_cycle", 64'(cyc), pending ? 64'(due) : 64'd0);
                pending = 0;
            end else if (pending && cyc > due) begin
                check("line_done_missing", 64'(LINE_DONE), 64'd1);
                pending = 0;
            end
            if (FIFO_RD_EN) check("rd_en_when_empty", 64'(FIFO_EMPTY), 64'd0);
            if (prev_stall) check("stall_hold", 64'({BIT_VALID, BIT_OUT, SOL, EOL}), 64'({1'b1, prev_v}));
            if (BIT_VALID && BIT_READY) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_bit", 64'(BIT_VALID), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("bit_sol_eol", 64'({BIT_OUT, SOL, EOL}), 64'(e));
                    if (e[0]) begin
                        pending = 1;
                        due     = cyc + GAP + 1;
                    end
                end
            end
            prev_stall = BIT_VALID && !BIT_READY;
            prev_v     = {BIT_OUT, SOL, EOL};
        end
    end

    initial begin
        logic [7:0] d[$];
        int n, fv, p0, len;

        drive_fifo();
        repeat (3) @(posedge CLK);
        #1;
        check("reset_outputs", 64'({FIFO_RD_EN, BIT_OUT, BIT_VALID, SOL, EOL, BUSY, LINE_DONE, STARVE}), 64'd0);
        RST = 1'b0;
        tick();

        // Basic line, full throughput
        ready_mode = 0;
        d = '{8'hA5, 8'h3C};
        expect_line(d); push_fifo(d);
        p0 = pops;
        start_line(2);
        wait_idle(n, fv, 0);
        check("a_first_valid", 64'(fv), 64'd1);
        check("a_busy_cycles", 64'(n), 64'(1 + 16 + GAP));
        check("a_pops", 64'(pops - p0), 64'd2);

        // Same data with toggling ready
        ready_mode = 1;
        expect_line(d); push_fifo(d);
        p0 = pops;
        start_line(2);
        wait_idle(n, fv, 0);
        check("b_pops", 64'(pops - p0), 64'd2);

        // Starvation mid-line
        ready_mode = 0;
        d = '{8'h96, 8'h0F, 8'hE1};
        expect_line(d);
        fifo_q.push_back(d[0]); drive_fifo();
        start_line(3);
        repeat (14) tick();
        check("starve_set", 64'(STARVE), 64'd1);
        check("starve_busy", 64'(BUSY), 64'd1);
        fifo_q.push_back(d[1]); fifo_q.push_back(d[2]); drive_fifo();
        wait_idle(n, fv, 0);
        check("starve_sticky", 64'(STARVE), 64'd1);
        STARVE_CLR = 1'b1;
        tick();
        STARVE_CLR = 1'b0;
        check("starve_clr", 64'(STARVE), 64'd0);

        // Empty FIFO on the first load does not count as starvation
        d = '{8'h01};
        expect_line(d);
        start_line(1);
        repeat (5) tick();
        check("first_load_no_starve", 64'(STARVE), 64'd0);
        check("first_load_busy", 64'(BUSY), 64'd1);
        push_fifo(d);
        wait_idle(n, fv, 0);

        // Ignored starts: zero length, and repeated START while busy
        p0 = pops;
        LINE_LEN = '0;
        START = 1'b1;
        tick();
        START = 1'b0;
        repeat (3) tick();
        check("len0_not_busy", 64'(BUSY), 64'd0);
        check("len0_no_pop", 64'(pops - p0), 64'd0);
        d = '{8'h3C};
        expect_line(d); push_fifo(d);
        fifo_q.push_back(8'hC3); drive_fifo();
        start_line(1);
        LINE_LEN = LEN_W'(2);
        wait_idle(n, fv, 1);
        check("busy_start_one_pop", 64'(pops - p0), 64'd1);
        check("busy_start_fifo_left", 64'(fifo_q.size()), 64'd1);
        d = '{8'hC3};
        expect_line(d);
        start_line(1);
        wait_idle(n, fv, 0);

        // Reset at bit 11 of a two-byte line
        d = '{8'h5A, 8'hC3};
        expect_line(d); push_fifo(d);
        start_line(2);
        repeat (12) tick();
        RST = 1'b1;
        #1;
        check("rst_mid_outputs", 64'({BIT_OUT, BIT_VALID, SOL, EOL, BUSY, LINE_DONE, STARVE}), 64'd0);
        exp_q.delete();
        repeat (2) tick();
        RST = 1'b0;
        tick();
        d = '{8'($urandom), 8'($urandom)};
        expect_line(d); push_fifo(d);
        start_line(2);
        wait_idle(n, fv, 0);
        check("post_rst_first_valid", 64'(fv), 64'd1);
        check("post_rst_busy_cycles", 64'(n), 64'(1 + 16 + GAP));

        // Randomised lines, ready patterns and FIFO gaps
        for (int k = 0; k < 12; k++) begin
            len = $urandom_range(1, 5);
            d.delete();
            for (int i = 0; i < len; i++) d.push_back(8'($urandom));
            ready_mode = (k < 3) ? 0 : $urandom_range(0, 2);
            hold_pct   = (k % 3 == 2) ? 30 : 0;
            expect_line(d); push_fifo(d);
            start_line(len);
            wait_idle(n, fv, 0);
            if (ready_mode == 0 && hold_pct == 0)
                check("rand_busy_cycles", 64'(n), 64'(1 + 8 * len + GAP));
            hold_pct = 0;
            STARVE_CLR = 1'b1;
            tick();
            STARVE_CLR = 1'b0;
        end

        repeat (8) tick();
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        check("fifo_drained", 64'(fifo_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
